// File: rtl/jk_drv_pkg.sv
// jk_drv_pkg
//   Shared definitions for the JK bank driver: command opcodes and the
//   driver FSM state encoding.
package jk_drv_pkg;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_TOGGLE = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_SET    = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/jk_bank_driver_excite.sv
// jk_excite
//   Combinational excitation generator. From the command opcode, the q
//   snapshot taken at accept time and the command data, produce the target
//   word and the J/K excitation that moves the bank from snap to target.
// Ports
//   op     in   2      command opcode (OP_LOAD/OP_TOGGLE/OP_CLEAR/OP_SET)
//   snap   in   WIDTH  bank q at accept time
//   data   in   WIDTH  LOAD value or bit mask
//   target out  WIDTH  word the bank must reach
//   j_nxt  out  WIDTH  J excitation for the drive cycle
//   k_nxt  out  WIDTH  K excitation for the drive cycle
module jk_excite
  import jk_drv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] snap,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] j_nxt,
  output logic [WIDTH-1:0] k_nxt
);

  logic [WIDTH-1:0] diff;

  // Target word derived from the snapshot according to the opcode.
  always_comb begin
    target = data;
    case (op)
      OP_LOAD:   target = data;
      OP_TOGGLE: target = snap ^ data;
      OP_CLEAR:  target = snap & ~data;
      OP_SET:    target = snap | data;
      default:   target = data;
    endcase
  end

  assign diff = target ^ snap;

  // TOGGLE uses the JK toggle code (j=k=1) on masked bits. Every other op
  // only excites bits that actually change, as a set (10) or reset (01),
  // so j=k=1 can never appear outside TOGGLE.
  always_comb begin
    j_nxt = '0;
    k_nxt = '0;
    if (op == OP_TOGGLE) begin
      j_nxt = data;
      k_nxt = data;
    end else begin
      j_nxt = diff & target;
      k_nxt = diff & ~target;
    end
  end

endmodule

// File: rtl/jk_bank_driver.sv
// jk_bank_driver
//   Command-driven initiator for an external bank of JK flip-flops. A command
//   is accepted in IDLE, a one-cycle J/K pulse is issued in DRIVE, WAIT
//   watches q_fb until it equals the target, and RESP holds the result until
//   the consumer takes it.
// Optional feature macro: JKDRV_TIMEOUT_EN
//   Defined   : WAIT gives up after TIMEOUT cycles and reports rsp_err=1.
//   Undefined : WAIT holds until a match; rsp_err is constant 0.
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      driver can accept a command (IDLE only)
//   cmd_op     in   2      00 LOAD, 01 TOGGLE, 10 CLEAR, 11 SET
//   cmd_data   in   WIDTH  LOAD value or bit mask
//   j          out  WIDTH  registered J drive
//   k          out  WIDTH  registered K drive
//   q_fb       in   WIDTH  bank Q outputs
//   rsp_valid  out  1      response present, held until rsp_ready
//   rsp_ready  in   1      response consumer ready
//   rsp_err    out  1      timeout before q_fb matched target
//   rsp_q      out  WIDTH  q_fb sampled on the match/timeout edge
module jk_bank_driver
  import jk_drv_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef JKDRV_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_q
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] target_c, j_c, k_c;
  logic             accept, match, timeout_hit;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = cmd_valid & cmd_ready;
  assign match     = (q_fb == target);

  // The snapshot is q_fb itself on the accept edge, so no separate snap
  // register is needed; only the derived target is kept.
  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .op     (cmd_op),
    .snap   (q_fb),
    .data   (cmd_data),
    .target (target_c),
    .j_nxt  (j_c),
    .k_nxt  (k_c)
  );

`ifdef JKDRV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          rsp_err_r;

  assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
  assign rsp_err     = rsp_err_r;

  // Counts unmatched WAIT cycles; cleared while driving so each command
  // starts its timeout window fresh.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      rsp_err_r <= 1'b0;
    end else begin
      if (state == DRIVE) begin
        wait_cnt <= '0;
      end else if (state == WAIT && !match) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      // A match on the same edge as the timeout wins.
      if (state == WAIT) begin
        if (match) begin
          rsp_err_r <= 1'b0;
        end else if (timeout_hit) begin
          rsp_err_r <= 1'b1;
        end
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DRIVE;
      DRIVE:   state_nxt = WAIT;
      WAIT:    if (match || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // J/K are loaded only on the accept edge and cleared on every other edge,
  // which gives exactly one cycle of excitation (the DRIVE cycle).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      j      <= '0;
      k      <= '0;
      target <= '0;
      rsp_q  <= '0;
    end else begin
      j <= '0;
      k <= '0;
      if (accept) begin
        j      <= j_c;
        k      <= k_c;
        target <= target_c;
      end
      if (state == WAIT && (match || timeout_hit)) begin
        rsp_q <= q_fb;
      end
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver
//   Directed bench for jk_bank_driver (WIDTH=8) driving a behavioural bank
//   of JK flip-flops whose clock can be gated. Table vectors cover each op
//   plus no-change commands; hand-written sequences cover response stall,
//   timeout (or endless wait without JKDRV_TIMEOUT_EN) and reset in WAIT.
module tb_jk_bank_driver;
  import jk_drv_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] j, k;
  logic [7:0] bankQ = 8'h00;
  logic       bankEn;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_err;
  logic [7:0] rsp_q;

  int numChecks = 0;
  int numFails  = 0;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] expJ;
    logic [7:0] expK;
    logic [7:0] expQ;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .j         (j),
    .k         (k),
    .q_fb      (bankQ),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_err   (rsp_err),
    .rsp_q     (rsp_q)
  );

  // Behavioural JK bank with a gateable clock.
  always @(posedge clk) begin
    if (bankEn) begin
      for (int i = 0; i < 8; i++) begin
        case ({j[i], k[i]})
          2'b10:   bankQ[i] <= 1'b1;
          2'b01:   bankQ[i] <= 1'b0;
          2'b11:   bankQ[i] <= ~bankQ[i];
          default: bankQ[i] <= bankQ[i];
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for rsp_valid, then one handshake cycle.
  task automatic finishResponse(input int maxCycles);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput("rsp_arrives", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
    checkOutput("cmd_ready_after_hs", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    checkOutput("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_data  = v.data;
    tick();
    cmd_valid = 1'b0;
    checkOutput("j_pulse", {24'd0, j}, {24'd0, v.expJ});
    checkOutput("k_pulse", {24'd0, k}, {24'd0, v.expK});
    checkOutput("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    tick();
    checkOutput("j_cleared", {24'd0, j}, 32'd0);
    checkOutput("k_cleared", {24'd0, k}, 32'd0);
    checkOutput("rsp_valid_early", {31'd0, rsp_valid}, 32'd0);
    tick();
    checkOutput("rsp_valid_lat2", {31'd0, rsp_valid}, 32'd1);
    checkOutput("rsp_q", {24'd0, rsp_q}, {24'd0, v.expQ});
    checkOutput("rsp_err", {31'd0, rsp_err}, 32'd0);
    finishResponse(40);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    vecs[0] = '{OP_LOAD,   8'hA5, 8'hA5, 8'h00, 8'hA5};
    vecs[1] = '{OP_TOGGLE, 8'h0F, 8'h0F, 8'h0F, 8'hAA};
    vecs[2] = '{OP_CLEAR,  8'hF0, 8'h00, 8'hA0, 8'h0A};
    vecs[3] = '{OP_SET,    8'h03, 8'h01, 8'h00, 8'h0B};
    vecs[4] = '{OP_CLEAR,  8'hF0, 8'h00, 8'h00, 8'h0B};
    vecs[5] = '{OP_SET,    8'h01, 8'h00, 8'h00, 8'h0B};
    vecs[6] = '{OP_LOAD,   8'h3C, 8'h34, 8'h03, 8'h3C};
    vecs[7] = '{OP_TOGGLE, 8'h00, 8'h00, 8'h00, 8'h3C};
    vecs[8] = '{OP_LOAD,   8'h3C, 8'h00, 8'h00, 8'h3C};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_LOAD;
    cmd_data  = 8'h00;
    rsp_ready = 1'b0;
    bankEn    = 1'b1;
    repeat (3) tick();
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rst_j", {24'd0, j}, 32'd0);
    checkOutput("rst_k", {24'd0, k}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    checkOutput("rst_rsp_q", {24'd0, rsp_q}, 32'd0);
    rst_n = 1'b1;

    $display("[TB] table vectors");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
    end

    $display("[TB] response stall with extra command");
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_data  = 8'h55;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    cmd_valid = 1'b1;
    cmd_data  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("stall_rsp_q", {24'd0, rsp_q}, 32'h55);
      checkOutput("stall_rsp_err", {31'd0, rsp_err}, 32'd0);
      checkOutput("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      checkOutput("stall_j", {24'd0, j}, 32'd0);
      tick();
    end
    cmd_valid = 1'b0;
    finishResponse(40);
    tick();
    checkOutput("stall_bank_unchanged", {24'd0, bankQ}, 32'h55);
    checkOutput("stall_still_idle", {31'd0, cmd_ready}, 32'd1);

    v = '{OP_LOAD, 8'h00, 8'h00, 8'h55, 8'h00};
    applyStimulus(v);

    $display("[TB] gated bank clock");
    bankEn    = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_data  = 8'hFF;
    tick();
    cmd_valid = 1'b0;
    tick();
`ifdef JKDRV_TIMEOUT_EN
    for (int i = 0; i < 14; i++) begin
      tick();
      checkOutput("to_rsp_valid_low", {31'd0, rsp_valid}, 32'd0);
    end
    tick();
    checkOutput("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    checkOutput("to_rsp_q", {24'd0, rsp_q}, 32'h00);
    finishResponse(40);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("nto_rsp_valid_low", {31'd0, rsp_valid}, 32'd0);
      checkOutput("nto_rsp_err", {31'd0, rsp_err}, 32'd0);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("nto_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
`endif
    bankEn = 1'b1;

    $display("[TB] reset during WAIT");
    bankEn    = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_data  = 8'h0F;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    checkOutput("wait_busy", {31'd0, cmd_ready}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("wrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("wrst_j", {24'd0, j}, 32'd0);
    checkOutput("wrst_k", {24'd0, k}, 32'd0);
    checkOutput("wrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("wrst_rsp_err", {31'd0, rsp_err}, 32'd0);
    checkOutput("wrst_rsp_q", {24'd0, rsp_q}, 32'd0);
    bankEn = 1'b1;
    tick();
    checkOutput("wrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    v = '{OP_LOAD, 8'h0F, 8'h0F, 8'h00, 8'h0F};
    applyStimulus(v);

    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
    $finish;
  end

endmodule
